// File: rtl/icmp_echo_responder.sv
`timescale 1ns / 1ps
// icmp_echo_responder
// Store-and-forward ICMP echo responder. One echo request is buffered in
// full, validated, and answered with swapped addresses, type rewritten to
// echo-reply (0) and the checksum patched incrementally (RFC 1624).
//
// Ports
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   s_ip_hdr_*                  : request IP header handshake + fields
//   s_ip_payload_axis_*         : request ICMP message bytes (tuser = bad frame)
//   m_ip_hdr_*                  : reply IP header handshake + fields
//   m_ip_payload_axis_*         : reply ICMP message bytes
//   o_reply_count, o_drop_count : saturating event counters
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request header
// ST_RX   | storing ICMP message bytes, validating type/code/length
// ST_DROP | non-ICMP packet, discarding bytes until tlast
// ST_HDR  | presenting reply IP header
// ST_TX   | streaming reply bytes from the buffer
module icmp_echo_responder #(
    parameter int unsigned MAX_BYTES = 512,
    parameter logic [7:0]  REPLY_TTL = 8'd64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        s_ip_hdr_valid,
    output logic        s_ip_hdr_ready,
    input  logic [7:0]  s_ip_protocol,
    input  logic [31:0] s_ip_source_ip,
    input  logic [31:0] s_ip_dest_ip,
    input  logic [7:0]  s_ip_payload_axis_tdata,
    input  logic        s_ip_payload_axis_tvalid,
    output logic        s_ip_payload_axis_tready,
    input  logic        s_ip_payload_axis_tlast,
    input  logic        s_ip_payload_axis_tuser,
    output logic        m_ip_hdr_valid,
    input  logic        m_ip_hdr_ready,
    output logic [5:0]  m_ip_dscp,
    output logic [1:0]  m_ip_ecn,
    output logic [15:0] m_ip_length,
    output logic [7:0]  m_ip_ttl,
    output logic [7:0]  m_ip_protocol,
    output logic [31:0] m_ip_source_ip,
    output logic [31:0] m_ip_dest_ip,
    output logic [7:0]  m_ip_payload_axis_tdata,
    output logic        m_ip_payload_axis_tvalid,
    input  logic        m_ip_payload_axis_tready,
    output logic        m_ip_payload_axis_tlast,
    output logic        m_ip_payload_axis_tuser,
    output logic [15:0] o_reply_count,
    output logic [15:0] o_drop_count
);

    localparam int AW = $clog2(MAX_BYTES);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_BYTES);
    localparam logic [CW-1:0] CNT_MIN  = CW'(8);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_DROP,
        ST_HDR,
        ST_TX
    } state_t;

    state_t        state_q, state_d;
    logic          live_q, live_d;
    logic [31:0]   src_q, src_d;
    logic [31:0]   dst_q, dst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bad_q, bad_d;
    logic [15:0]   old_csum_q, old_csum_d;
    logic [CW-1:0] tx_idx_q, tx_idx_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [15:0]   reply_cnt_q, reply_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic [7:0]    mem [MAX_BYTES];
    logic [7:0]    rd_data_q;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;

    logic [CW-1:0] cnt_nx;
    logic          bad_nx;
    logic [7:0]    tx_byte;
    logic [16:0]   csum_sum;
    logic [16:0]   csum_fold;
    logic [15:0]   new_csum;

    // Type 8 -> 0 changes the first checksummed word by 0x0800; ~0x0800 = 0xF7FF.
    always_comb begin
        csum_sum  = {1'b0, ~old_csum_q} + 17'h0F7FF;
        csum_fold = {1'b0, csum_sum[15:0]} + {16'b0, csum_sum[16]};
        new_csum  = ~csum_fold[15:0];
    end

    // live_q keeps s_ip_hdr_ready low until the first clock after reset release.
    assign s_ip_hdr_ready           = (state_q == ST_IDLE) && live_q;
    assign s_ip_payload_axis_tready = (state_q == ST_RX) || (state_q == ST_DROP);
    assign m_ip_hdr_valid           = (state_q == ST_HDR);
    assign m_ip_dscp                = 6'd0;
    assign m_ip_ecn                 = 2'd0;
    assign m_ip_length              = m_ip_hdr_valid ? (16'd20 + 16'(cnt_q)) : 16'd0;
    assign m_ip_ttl                 = m_ip_hdr_valid ? REPLY_TTL : 8'd0;
    assign m_ip_protocol            = m_ip_hdr_valid ? 8'h01 : 8'd0;
    assign m_ip_source_ip           = m_ip_hdr_valid ? dst_q : 32'd0;
    assign m_ip_dest_ip             = m_ip_hdr_valid ? src_q : 32'd0;
    assign m_ip_payload_axis_tdata  = out_data_q;
    assign m_ip_payload_axis_tvalid = out_valid_q;
    assign m_ip_payload_axis_tlast  = out_last_q;
    assign m_ip_payload_axis_tuser  = 1'b0;
    assign o_reply_count            = reply_cnt_q;
    assign o_drop_count             = drop_cnt_q;

    always_comb begin
        if (tx_idx_q == '0) begin
            tx_byte = 8'h00;
        end else if (tx_idx_q == CW'(2)) begin
            tx_byte = new_csum[15:8];
        end else if (tx_idx_q == CW'(3)) begin
            tx_byte = new_csum[7:0];
        end else begin
            tx_byte = rd_data_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        live_d      = 1'b1;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        bad_d       = bad_q;
        old_csum_d  = old_csum_q;
        tx_idx_d    = tx_idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        reply_cnt_d = reply_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = cnt_q[AW-1:0];
        // Read address tracks the next byte to load so rd_data_q is ready for it.
        mem_raddr   = tx_idx_q[AW-1:0];
        cnt_nx      = cnt_q;
        bad_nx      = bad_q;

        case (state_q)
            ST_IDLE: begin
                if (s_ip_hdr_valid && live_q) begin
                    src_d      = s_ip_source_ip;
                    dst_d      = s_ip_dest_ip;
                    cnt_d      = '0;
                    bad_d      = 1'b0;
                    old_csum_d = 16'd0;
                    tx_idx_d   = '0;
                    state_d    = (s_ip_protocol == 8'h01) ? ST_RX : ST_DROP;
                end
            end
            ST_RX: begin
                if (s_ip_payload_axis_tvalid) begin
                    if (cnt_q == CNT_FULL) begin
                        bad_nx = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        cnt_nx = cnt_q + CNT_ONE;
                    end
                    if ((cnt_q == '0) && (s_ip_payload_axis_tdata != 8'h08)) begin
                        bad_nx = 1'b1;
                    end
                    if ((cnt_q == CNT_ONE) && (s_ip_payload_axis_tdata != 8'h00)) begin
                        bad_nx = 1'b1;
                    end
                    if (cnt_q == CW'(2)) begin
                        old_csum_d[15:8] = s_ip_payload_axis_tdata;
                    end
                    if (cnt_q == CW'(3)) begin
                        old_csum_d[7:0] = s_ip_payload_axis_tdata;
                    end
                    cnt_d = cnt_nx;
                    bad_d = bad_nx;
                    if (s_ip_payload_axis_tlast) begin
                        if (bad_nx || s_ip_payload_axis_tuser || (cnt_nx < CNT_MIN)) begin
                            if (drop_cnt_q != 16'hFFFF) begin
                                drop_cnt_d = drop_cnt_q + 16'd1;
                            end
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HDR;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) begin
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (m_ip_hdr_ready) begin
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (out_valid_q && m_ip_payload_axis_tready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (reply_cnt_q != 16'hFFFF) begin
                        reply_cnt_d = reply_cnt_q + 16'd1;
                    end
                    state_d = ST_IDLE;
                end else if ((!out_valid_q || m_ip_payload_axis_tready) && (tx_idx_q < cnt_q)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = tx_byte;
                    out_last_d  = (tx_idx_q == (cnt_q - CNT_ONE));
                    tx_idx_d    = tx_idx_q + CNT_ONE;
                    mem_raddr   = tx_idx_d[AW-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            live_q      <= 1'b0;
            src_q       <= 32'd0;
            dst_q       <= 32'd0;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            old_csum_q  <= 16'd0;
            tx_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 8'd0;
            reply_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            live_q      <= live_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            old_csum_q  <= old_csum_d;
            tx_idx_q    <= tx_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            reply_cnt_q <= reply_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Message buffer with registered read; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= s_ip_payload_axis_tdata;
        end
        rd_data_q <= mem[mem_raddr];
    end

endmodule

// File: tb/tb_icmp_echo_responder.sv
`timescale 1ns / 1ps
module tb_icmp_echo_responder;

    localparam int MAX_BYTES = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_hdr_valid, s_hdr_ready;
    logic [7:0]  s_proto;
    logic [31:0] s_src, s_dst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic        m_hdr_valid, m_hdr_ready;
    logic [5:0]  m_dscp;
    logic [1:0]  m_ecn;
    logic [15:0] m_len;
    logic [7:0]  m_ttl, m_proto;
    logic [31:0] m_src, m_dst;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic [15:0] reply_cnt, drop_cnt;

    always #5 clk = ~clk;

    icmp_echo_responder #(.MAX_BYTES(MAX_BYTES), .REPLY_TTL(8'd64)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_ip_hdr_valid(s_hdr_valid), .s_ip_hdr_ready(s_hdr_ready),
        .s_ip_protocol(s_proto), .s_ip_source_ip(s_src), .s_ip_dest_ip(s_dst),
        .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tvalid(s_tvalid),
        .s_ip_payload_axis_tready(s_tready), .s_ip_payload_axis_tlast(s_tlast),
        .s_ip_payload_axis_tuser(s_tuser),
        .m_ip_hdr_valid(m_hdr_valid), .m_ip_hdr_ready(m_hdr_ready),
        .m_ip_dscp(m_dscp), .m_ip_ecn(m_ecn), .m_ip_length(m_len),
        .m_ip_ttl(m_ttl), .m_ip_protocol(m_proto),
        .m_ip_source_ip(m_src), .m_ip_dest_ip(m_dst),
        .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tvalid(m_tvalid),
        .m_ip_payload_axis_tready(m_tready), .m_ip_payload_axis_tlast(m_tlast),
        .m_ip_payload_axis_tuser(m_tuser),
        .o_reply_count(reply_cnt), .o_drop_count(drop_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
    } hdr_t;

    // Reference model state
    logic [7:0] pb[$];
    logic [7:0] exp_b[$];
    logic       exp_l[$];
    hdr_t       exp_h[$];
    int         exp_reply = 0;
    int         exp_drop  = 0;

    // Captured last reply
    logic [7:0] cap_b[$];
    hdr_t       cap_h;

    bit rand_mode = 0;
    bit strict_rate = 0;

    // RFC 1624: HC' = ~(~HC + ~m + m'), m = 0x0800 (type 8 code 0), m' = 0x0000
    function automatic logic [15:0] csum_upd(input logic [15:0] hc);
        int s;
        s = {16'h0, ~hc} + {16'h0, ~16'h0800} + 0;
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic model_push(input logic [31:0] src, input logic [31:0] dst);
        logic [15:0] nc;
        int n;
        n  = pb.size();
        nc = csum_upd({pb[2], pb[3]});
        exp_h.push_back(hdr_t'{src: dst, dst: src, len: 16'(20 + n)});
        for (int i = 0; i < n; i++) begin
            if (i == 0)      exp_b.push_back(8'h00);
            else if (i == 2) exp_b.push_back(nc[15:8]);
            else if (i == 3) exp_b.push_back(nc[7:0]);
            else             exp_b.push_back(pb[i]);
            exp_l.push_back(i == n - 1);
        end
    endtask

    initial begin
        m_tready = 1'b1;
        m_hdr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_tready    = rand_mode ? 1'($urandom_range(1)) : 1'b1;
            m_hdr_ready = rand_mode ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Output monitor
    bit         in_pkt = 0, first_seen = 0;
    int         since_hdr = 0;
    bit         prev_stall = 0, prev_hstall = 0, prev_hs_byte = 0, prev_final = 0;
    logic [7:0] prev_data;
    logic       prev_last;
    hdr_t       prev_h;

    always @(negedge clk) begin
        hdr_t cur, e;
        cur = hdr_t'{src: m_src, dst: m_dst, len: m_len};
        if (!rst_n) begin
            prev_stall = 0; prev_hstall = 0; prev_hs_byte = 0; prev_final = 0; in_pkt = 0;
        end else begin
            if (prev_stall) begin
                chk_eq("stall_tvalid", m_tvalid, 1'b1);
                chk_eq("stall_tdata", m_tdata, prev_data);
                chk_eq("stall_tlast", m_tlast, prev_last);
            end
            if (prev_hstall) begin
                chk_eq("hdr_hold_valid", m_hdr_valid, 1'b1);
                chk_eq("hdr_hold_fields", cur, prev_h);
            end
            if (prev_final) chk_eq("idle_reentry_ready", s_hdr_ready, 1'b1);
            if (strict_rate && prev_hs_byte) chk_eq("sustained_rate", m_tvalid, 1'b1);
            if (m_hdr_valid || m_tvalid)
                chk_eq("rx_held_busy", {s_hdr_ready, s_tready}, 2'b00);
            if (m_hdr_valid) chk_eq("hdr_payload_overlap", m_tvalid, 1'b0);
            if (m_tvalid) chk_eq("tx_tuser", m_tuser, 1'b0);
            if (in_pkt && !first_seen) begin
                since_hdr++;
                if (m_tvalid) begin
                    first_seen = 1;
                    chk_eq("first_byte_latency_le2", since_hdr <= 2, 1'b1);
                end
            end
            if (m_hdr_valid && m_hdr_ready) begin
                if (exp_h.size() == 0) begin
                    chk_eq("hdr_expected", exp_h.size() > 0, 1'b1);
                end else begin
                    e = exp_h.pop_front();
                    chk_eq("hdr_src", m_src, e.src);
                    chk_eq("hdr_dst", m_dst, e.dst);
                    chk_eq("hdr_len", m_len, e.len);
                    chk_eq("hdr_ttl_proto", {m_ttl, m_proto}, {8'd64, 8'h01});
                    chk_eq("hdr_dscp_ecn", {m_dscp, m_ecn}, 8'h00);
                end
                cap_h = cur;
                cap_b.delete();
                in_pkt = 1; first_seen = 0; since_hdr = 0;
            end
            if (m_tvalid && m_tready) begin
                if (exp_b.size() == 0) begin
                    chk_eq("byte_expected", exp_b.size() > 0, 1'b1);
                end else begin
                    chk_eq("tx_byte", m_tdata, exp_b.pop_front());
                    chk_eq("tx_tlast", m_tlast, exp_l.pop_front());
                end
                cap_b.push_back(m_tdata);
                if (m_tlast) in_pkt = 0;
            end
            prev_stall   = m_tvalid && !m_tready;
            prev_data    = m_tdata;
            prev_last    = m_tlast;
            prev_hstall  = m_hdr_valid && !m_hdr_ready;
            prev_h       = cur;
            prev_hs_byte = m_tvalid && m_tready && !m_tlast;
            prev_final   = m_tvalid && m_tready && m_tlast;
        end
    end

    task automatic send_pkt(input logic [7:0] proto, input logic [31:0] src,
                            input logic [31:0] dst, input bit bad_user);
        int n;
        bit good, ok;
        n = pb.size();
        good = (proto == 8'h01) && (n >= 8) && (n <= MAX_BYTES) &&
               (pb[0] == 8'h08) && (pb[1] == 8'h00) && !bad_user;
        if (good) model_push(src, dst);
        s_hdr_valid = 1; s_proto = proto; s_src = src; s_dst = dst;
        ok = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (s_hdr_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        s_hdr_valid = 0;
        if (!ok) begin chk_eq("rx_hdr_timeout", ok, 1'b1); return; end
        for (int i = 0; i < n; i++) begin
            while (rand_mode && $urandom_range(3) == 0) begin
                s_tvalid = 0; @(posedge clk); #1;
            end
            s_tvalid = 1; s_tdata = pb[i];
            s_tlast = (i == n - 1); s_tuser = (i == n - 1) && bad_user;
            ok = 0;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                if (s_tready) begin ok = 1; break; end
            end
            @(posedge clk); #1;
            if (!ok) begin
                chk_eq("rx_beat_timeout", ok, 1'b1);
                s_tvalid = 0; s_tlast = 0; s_tuser = 0;
                return;
            end
        end
        s_tvalid = 0; s_tlast = 0; s_tuser = 0;
        chk_eq("hdr_valid_after_rx_tlast", m_hdr_valid, good);
        if (good) exp_reply++;
        else begin
            exp_drop++;
            chk_eq("drop_ready_after_tlast", s_hdr_ready, 1'b1);
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (exp_b.size() == 0 && exp_h.size() == 0 && s_hdr_ready) begin ok = 1; break; end
        end
        chk_eq("drain_done", ok, 1'b1);
        chk_eq("reply_count", reply_cnt, 16'(exp_reply));
        chk_eq("drop_count", drop_cnt, 16'(exp_drop));
        @(posedge clk); #1;
    endtask

    task automatic make_pkt(input int n, input logic [15:0] csum);
        pb.delete();
        for (int i = 0; i < n; i++) pb.push_back(8'($urandom));
        if (n > 0) pb[0] = 8'h08;
        if (n > 1) pb[1] = 8'h00;
        if (n > 2) pb[2] = csum[15:8];
        if (n > 3) pb[3] = csum[7:0];
    endtask

    initial begin
        #9000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst_n = 0;
        s_hdr_valid = 0; s_proto = 0; s_src = 0; s_dst = 0;
        s_tdata = 0; s_tvalid = 0; s_tlast = 0; s_tuser = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk_eq("rst_ready", {s_hdr_ready, s_tready}, 2'b00);
        chk_eq("rst_valids", {m_hdr_valid, m_tvalid, m_tlast}, 3'b000);
        chk_eq("rst_data", {m_tdata, m_ttl, m_proto, m_len}, 40'd0);
        chk_eq("rst_counts", {reply_cnt, drop_cnt}, 32'd0);
        rst_n = 1;
        #1 chk_eq("ready_before_first_clk", s_hdr_ready, 1'b0);
        @(posedge clk); #1;
        chk_eq("ready_after_first_clk", s_hdr_ready, 1'b1);

        // 64-byte echo request 10.0.0.5 -> 172.0.0.2
        strict_rate = 1;
        make_pkt(64, 16'h1234);
        pb[4] = 8'h12; pb[5] = 8'h34; pb[6] = 8'h00; pb[7] = 8'h01;
        send_pkt(8'h01, 32'h0A000005, 32'hAC000002, 0);
        wait_drain();
        chk_eq("ref_src", cap_h.src, 32'hAC000002);
        chk_eq("ref_dst", cap_h.dst, 32'h0A000005);
        chk_eq("ref_len", cap_h.len, 16'd84);
        chk_eq("ref_size", cap_b.size(), 64);
        chk_eq("ref_type", cap_b[0], 8'h00);
        chk_eq("ref_csum", {cap_b[2], cap_b[3]}, 16'h1A34);
        chk_eq("ref_reply_count", reply_cnt, 16'd1);

        // Checksum corners
        make_pkt(16, 16'hF800);
        send_pkt(8'h01, 32'h01020304, 32'h05060708, 0);
        wait_drain();
        chk_eq("csum_F800", {cap_b[2], cap_b[3]}, 16'h0001);
        make_pkt(8, 16'hF7FF);
        send_pkt(8'h01, 32'h01020304, 32'h05060708, 0);
        wait_drain();
        chk_eq("csum_F7FF", {cap_b[2], cap_b[3]}, 16'h0000);
        strict_rate = 0;

        // Drop cases
        make_pkt(20, 16'h5555); pb[0] = 8'h00;
        send_pkt(8'h01, 32'h11111111, 32'h22222222, 0); wait_drain();
        make_pkt(20, 16'h5555); pb[1] = 8'h01;
        send_pkt(8'h01, 32'h11111111, 32'h22222222, 0); wait_drain();
        make_pkt(20, 16'h5555);
        send_pkt(8'h01, 32'h11111111, 32'h22222222, 1); wait_drain();
        make_pkt(6, 16'h5555);
        send_pkt(8'h01, 32'h11111111, 32'h22222222, 0); wait_drain();
        make_pkt(MAX_BYTES + 1, 16'h5555);
        send_pkt(8'h01, 32'h11111111, 32'h22222222, 0); wait_drain();
        make_pkt(20, 16'h5555);
        send_pkt(8'd17, 32'h11111111, 32'h22222222, 0); wait_drain();
        chk_eq("drops_total", drop_cnt, 16'd6);

        // Random traffic with random backpressure
        rand_mode = 1;
        for (int k = 0; k < 10; k++) begin
            make_pkt($urandom_range(150, 8), 16'($urandom));
            if ($urandom_range(4) == 0) begin
                if ($urandom_range(1) == 0) pb[0] = 8'h08 ^ 8'($urandom_range(255, 1));
                else                        pb[1] = 8'($urandom_range(255, 1));
            end
            send_pkt(8'h01, $urandom, $urandom, 0);
        end
        wait_drain();

        // 100-byte reply with a second request queued behind it
        make_pkt(100, 16'($urandom));
        send_pkt(8'h01, 32'hC0A80001, 32'hC0A80002, 0);
        chk_eq("busy_after_rx", s_hdr_ready, 1'b0);
        make_pkt(20, 16'($urandom));
        send_pkt(8'h01, 32'hC0A80003, 32'hC0A80004, 0);
        wait_drain();
        chk_eq("second_reply_size", cap_b.size(), 20);
        rand_mode = 0;

        // Reset in the middle of a reply
        make_pkt(40, 16'h0BAD);
        send_pkt(8'h01, 32'h0A0A0A0A, 32'h0B0B0B0B, 0);
        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (cap_b.size() >= 5) begin ok = 1; break; end
        end
        chk_eq("midtx_reached", ok, 1'b1);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk_eq("midrst_valids", {m_hdr_valid, m_tvalid, m_tlast, s_hdr_ready}, 4'b0000);
        chk_eq("midrst_tdata", m_tdata, 8'h00);
        chk_eq("midrst_counts", {reply_cnt, drop_cnt}, 32'd0);
        exp_b.delete(); exp_l.delete(); exp_h.delete();
        exp_reply = 0; exp_drop = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1;
        @(posedge clk); #1;
        make_pkt(30, 16'h4321);
        send_pkt(8'h01, 32'h0C0C0C0C, 32'h0D0D0D0D, 0);
        wait_drain();
        chk_eq("post_reset_size", cap_b.size(), 30);
        chk_eq("post_reset_reply", reply_cnt, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
